// File: rtl/router_flit_fifo_pkg.sv
// Shared defaults and types for the router input-port flit FIFO.
// Imported by the byte packer and the flit queue.
package router_flit_fifo_pkg;

  localparam int DEF_BYTE_W         = 8;
  localparam int DEF_BYTES_PER_FLIT = 4;
  localparam int DEF_DEPTH          = 16;
  localparam int DEF_THRESH         = 12;

  // Status flags, all registered from the next-state count so they agree with flit_count.
  typedef struct packed {
    logic overflow;
    logic underflow;
    logic threshold;
    logic full;
    logic empty;
  } fifo_flags_t;

  localparam fifo_flags_t FLAGS_RESET = '{
    overflow:  1'b0,
    underflow: 1'b0,
    threshold: 1'b0,
    full:      1'b0,
    empty:     1'b1
  };

  // Index width that stays legal when a range collapses to a single value.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/router_flit_packer.sv
// Little-endian byte-to-flit assembler. Emits a one-cycle push with the
// completed flit when the last byte of a flit is accepted.
module router_flit_packer
  import router_flit_fifo_pkg::*;
#(
  parameter int BYTE_W         = DEF_BYTE_W,
  parameter int BYTES_PER_FLIT = DEF_BYTES_PER_FLIT,
  parameter int FLIT_W         = BYTE_W * BYTES_PER_FLIT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_i,
  input  logic [BYTE_W-1:0] data_i,
  input  logic              flush_i,
  input  logic              fifo_full_i,
  output logic              wr_ready_o,
  output logic              drop_o,
  output logic              flit_push_o,
  output logic [FLIT_W-1:0] flit_o
);

  localparam int IDX_W = idx_width(BYTES_PER_FLIT);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES_PER_FLIT - 1);

  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [FLIT_W-1:0] buf_q, buf_d;
  logic              last_byte;
  logic              accept;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    idx_d       = idx_q;
    buf_d       = buf_q;
    last_byte   = (idx_q == LAST_IDX);
    // Conservative: a pop in the same cycle does not make room for the completing byte.
    wr_ready_o  = !(last_byte && fifo_full_i);
    accept      = wr_i && wr_ready_o && !flush_i;
    drop_o      = wr_i && !wr_ready_o && !flush_i;
    flit_push_o = accept && last_byte;

    flit_o = buf_q;
    flit_o[FLIT_W-BYTE_W +: BYTE_W] = data_i;

    if (flush_i) begin
      idx_d = '0;
    end else if (accept) begin
      for (int b = 0; b < BYTES_PER_FLIT; b++) begin
        if (idx_q == IDX_W'(b)) buf_d[b*BYTE_W +: BYTE_W] = data_i;
      end
      idx_d = last_byte ? '0 : idx_q + 1'b1;
    end
  end

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) idx_q <= '0;
    else        idx_q <= idx_d;
  end

  // Byte lanes are qualified by idx_q, so stale contents after reset are never observed.
  always_ff @(posedge clk) begin
    buf_q <= buf_d;
  end

endmodule

// File: rtl/router_flit_fifo.sv
// Router input-port buffer: packs bytes into flits and queues them in a
// first-word-fall-through circular buffer with level and sticky error flags.
module router_flit_fifo
  import router_flit_fifo_pkg::*;
#(
  parameter int BYTE_W         = DEF_BYTE_W,
  parameter int BYTES_PER_FLIT = DEF_BYTES_PER_FLIT,
  parameter int DEPTH          = DEF_DEPTH,
  parameter int THRESH         = DEF_THRESH
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 wr,
  input  logic [BYTE_W-1:0]                    data_in,
  output logic                                 wr_ready,
  input  logic                                 rd,
  output logic [BYTE_W*BYTES_PER_FLIT-1:0]     flit,
  output logic                                 flit_avl,
  input  logic                                 flush,
  input  logic                                 err_clr,
  output logic                                 fifo_full,
  output logic                                 fifo_empty,
  output logic                                 fifo_threshold,
  output logic                                 fifo_overflow,
  output logic                                 fifo_underflow,
  output logic [$clog2(DEPTH+1)-1:0]           flit_count
);

  localparam int FLIT_W = BYTE_W * BYTES_PER_FLIT;
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(DEPTH + 1);

  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] THRESH_C = CNT_W'(THRESH);

  logic [FLIT_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  fifo_flags_t       flags_q, flags_d;

  logic              push;
  logic              pop;
  logic              drop;
  logic              bad_rd;
  logic [FLIT_W-1:0] push_flit;

  router_flit_packer #(
    .BYTE_W         (BYTE_W),
    .BYTES_PER_FLIT (BYTES_PER_FLIT),
    .FLIT_W         (FLIT_W)
  ) u_packer (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_i        (wr),
    .data_i      (data_in),
    .flush_i     (flush),
    .fifo_full_i (flags_q.full),
    .wr_ready_o  (wr_ready),
    .drop_o      (drop),
    .flit_push_o (push),
    .flit_o      (push_flit)
  );

  always_comb begin
    pop      = rd && !flags_q.empty && !flush;
    bad_rd   = rd && flags_q.empty && !flush;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
      unique case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end

    flags_d.empty     = (count_d == '0);
    flags_d.full      = (count_d == DEPTH_C);
    flags_d.threshold = (count_d >= THRESH_C);
    // A fresh error in the clearing cycle takes priority over err_clr.
    flags_d.overflow  = (flags_q.overflow  && !err_clr) || drop;
    flags_d.underflow = (flags_q.underflow && !err_clr) || bad_rd;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      flags_q  <= FLAGS_RESET;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      flags_q  <= flags_d;
    end
  end

  // NOTE: storage is deliberately left unreset; entries are only read once the count covers them.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_flit;
  end

  assign flit           = mem_q[rd_ptr_q];
  assign flit_avl       = !flags_q.empty;
  assign fifo_full      = flags_q.full;
  assign fifo_empty     = flags_q.empty;
  assign fifo_threshold = flags_q.threshold;
  assign fifo_overflow  = flags_q.overflow;
  assign fifo_underflow = flags_q.underflow;
  assign flit_count     = count_q;

endmodule

// File: tb/tb_router_flit_fifo.sv
// Self-checking bench for router_flit_fifo: directed scenarios plus a
// randomized run compared against a queue-based reference model.
module tb_router_flit_fifo;

  localparam int BPF    = 4;
  localparam int DEPTH  = 4;
  localparam int THRESH = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr = 1'b0;
  logic [7:0]  data_in = '0;
  logic        wr_ready;
  logic        rd = 1'b0;
  logic [31:0] flit;
  logic        flit_avl;
  logic        flush = 1'b0;
  logic        err_clr = 1'b0;
  logic        fifo_full, fifo_empty, fifo_threshold, fifo_overflow, fifo_underflow;
  logic [2:0]  flit_count;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: pending bytes of the current flit, queued flits, sticky errors.
  logic [7:0]  m_pend[$];
  logic [31:0] m_q[$];
  bit          m_ovf, m_udf;

  router_flit_fifo #(
    .BYTE_W(8), .BYTES_PER_FLIT(BPF), .DEPTH(DEPTH), .THRESH(THRESH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .wr(wr), .data_in(data_in), .wr_ready(wr_ready),
    .rd(rd), .flit(flit), .flit_avl(flit_avl), .flush(flush), .err_clr(err_clr),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty), .fifo_threshold(fifo_threshold),
    .fifo_overflow(fifo_overflow), .fifo_underflow(fifo_underflow), .flit_count(flit_count)
  );

  always #5 clk = ~clk;

  task automatic model_clear();
    m_pend.delete();
    m_q.delete();
    m_ovf = 1'b0;
    m_udf = 1'b0;
  endtask

  // Drive one cycle of inputs, advance the model, sample point is 1ns after the edge.
  task automatic cyc(input bit w, input logic [7:0] d, input bit r, input bit f, input bit c);
    bit          ready, ev_o, ev_u;
    logic [31:0] fl;
    wr = w; data_in = d; rd = r; flush = f; err_clr = c;
    ready = !(m_pend.size() == BPF-1 && m_q.size() == DEPTH);
    ev_o = 1'b0;
    ev_u = 1'b0;
    if (f) begin
      m_pend.delete();
      m_q.delete();
    end else begin
      if (r) begin
        if (m_q.size() > 0) void'(m_q.pop_front());
        else ev_u = 1'b1;
      end
      if (w) begin
        if (ready) begin
          m_pend.push_back(d);
          if (m_pend.size() == BPF) begin
            fl = '0;
            for (int i = 0; i < BPF; i++) fl[i*8 +: 8] = m_pend[i];
            m_q.push_back(fl);
            m_pend.delete();
          end
        end else ev_o = 1'b1;
      end
    end
    m_ovf = (m_ovf && !c) || ev_o;
    m_udf = (m_udf && !c) || ev_u;
    @(posedge clk);
    #1;
    wr = 1'b0; rd = 1'b0; flush = 1'b0; err_clr = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_clear();
  endtask

  task automatic test_reset();
    do_reset();
    cyc(1, 8'h01, 0, 0, 0);
    cyc(1, 8'h02, 0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({fifo_empty, flit_count, fifo_full, fifo_threshold, flit_avl, fifo_overflow, fifo_underflow} !== {1'b1, 3'd0, 5'b0}) begin
      n_errors++;
      $display("FAIL reset_state: got empty=%0b count=%0d full=%0b thr=%0b avl=%0b ovf=%0b udf=%0b, need empty=1 count=0 others 0",
               fifo_empty, flit_count, fifo_full, fifo_threshold, flit_avl, fifo_overflow, fifo_underflow);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_clear();
    for (int b = 3; b <= 6; b++) cyc(1, 8'(b), 0, 0, 0);
    n_checks++;
    if (flit_avl !== 1'b1 || flit !== 32'h06050403) begin
      n_errors++;
      $display("FAIL reset_partial_discard: got avl=%0b flit=%h, need avl=1 flit=06050403", flit_avl, flit);
    end
  endtask

  task automatic test_single_flit();
    do_reset();
    for (int b = 1; b <= 3; b++) cyc(1, 8'(b), 0, 0, 0);
    n_checks++;
    if (flit_avl !== 1'b0 || flit_count !== 3'd0) begin
      n_errors++;
      $display("FAIL partial_not_visible: got avl=%0b count=%0d, need avl=0 count=0", flit_avl, flit_count);
    end
    cyc(1, 8'h04, 0, 0, 0);
    n_checks++;
    if (flit_avl !== 1'b1 || flit !== 32'h04030201 || flit_count !== 3'd1) begin
      n_errors++;
      $display("FAIL single_flit: got avl=%0b flit=%h count=%0d, need avl=1 flit=04030201 count=1", flit_avl, flit, flit_count);
    end
  endtask

  task automatic test_fill_overflow();
    do_reset();
    for (int k = 1; k <= 16; k++) begin
      cyc(1, 8'(k), 0, 0, 0);
      if (k == 8) begin
        n_checks++;
        if (fifo_threshold !== 1'b0 || flit_count !== 3'd2) begin
          n_errors++;
          $display("FAIL thresh_below: got thr=%0b count=%0d, need thr=0 count=2", fifo_threshold, flit_count);
        end
      end
      if (k == 12) begin
        n_checks++;
        if (fifo_threshold !== 1'b1 || fifo_full !== 1'b0 || flit_count !== 3'd3) begin
          n_errors++;
          $display("FAIL thresh_at: got thr=%0b full=%0b count=%0d, need thr=1 full=0 count=3", fifo_threshold, fifo_full, flit_count);
        end
      end
    end
    n_checks++;
    if (fifo_full !== 1'b1 || flit_count !== 3'd4 || wr_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL full: got full=%0b count=%0d rdy=%0b, need full=1 count=4 rdy=1", fifo_full, flit_count, wr_ready);
    end
    for (int b = 8'h11; b <= 8'h13; b++) cyc(1, 8'(b), 0, 0, 0);
    n_checks++;
    if (wr_ready !== 1'b0 || fifo_overflow !== 1'b0) begin
      n_errors++;
      $display("FAIL ready_low_last_byte: got rdy=%0b ovf=%0b, need rdy=0 ovf=0", wr_ready, fifo_overflow);
    end
    cyc(1, 8'h14, 0, 0, 0);
    n_checks++;
    if (fifo_overflow !== 1'b1 || flit_count !== 3'd4 || flit !== 32'h04030201) begin
      n_errors++;
      $display("FAIL overflow_drop: got ovf=%0b count=%0d head=%h, need ovf=1 count=4 head=04030201", fifo_overflow, flit_count, flit);
    end
    cyc(0, 8'h00, 1, 0, 0);
    n_checks++;
    if (flit_count !== 3'd3 || flit !== 32'h08070605 || wr_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL pop_after_full: got count=%0d head=%h rdy=%0b, need count=3 head=08070605 rdy=1", flit_count, flit, wr_ready);
    end
    cyc(1, 8'h14, 0, 0, 0);
    for (int p = 0; p < 3; p++) cyc(0, 8'h00, 1, 0, 0);
    n_checks++;
    if (flit !== 32'h14131211 || flit_count !== 3'd1) begin
      n_errors++;
      $display("FAIL retry_tail: got head=%h count=%0d, need head=14131211 count=1", flit, flit_count);
    end
  endtask

  task automatic test_underflow();
    do_reset();
    cyc(0, 8'h00, 1, 0, 0);
    n_checks++;
    if (fifo_underflow !== 1'b1 || flit_count !== 3'd0 || fifo_empty !== 1'b1) begin
      n_errors++;
      $display("FAIL underflow_set: got udf=%0b count=%0d empty=%0b, need udf=1 count=0 empty=1", fifo_underflow, flit_count, fifo_empty);
    end
    cyc(0, 8'h00, 0, 0, 1);
    n_checks++;
    if (fifo_underflow !== 1'b0) begin
      n_errors++;
      $display("FAIL underflow_clear: got udf=%0b, need 0", fifo_underflow);
    end
    cyc(0, 8'h00, 1, 0, 1);
    n_checks++;
    if (fifo_underflow !== 1'b1 || fifo_overflow !== 1'b0) begin
      n_errors++;
      $display("FAIL underflow_clear_race: got udf=%0b ovf=%0b, need udf=1 ovf=0", fifo_underflow, fifo_overflow);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int b = 1; b <= 11; b++) cyc(1, 8'(b), 0, 0, 0);
    cyc(1, 8'h0c, 1, 0, 0);
    n_checks++;
    if (flit_count !== 3'd2 || flit !== 32'h08070605) begin
      n_errors++;
      $display("FAIL push_pop_same: got count=%0d head=%h, need count=2 head=08070605", flit_count, flit);
    end
    cyc(0, 8'h00, 1, 0, 0);
    n_checks++;
    if (flit_count !== 3'd1 || flit !== 32'h0c0b0a09) begin
      n_errors++;
      $display("FAIL order_kept: got count=%0d head=%h, need count=1 head=0c0b0a09", flit_count, flit);
    end
  endtask

  task automatic test_flush();
    do_reset();
    for (int b = 1; b <= 19; b++) cyc(1, 8'(b), 0, 0, 0);
    cyc(1, 8'h66, 0, 0, 0);
    for (int p = 0; p < 4; p++) cyc(0, 8'h00, 1, 0, 0);
    cyc(1, 8'hAA, 0, 0, 0);
    cyc(1, 8'hBB, 0, 0, 0);
    cyc(0, 8'h00, 0, 1, 0);
    n_checks++;
    if (fifo_empty !== 1'b1 || flit_count !== 3'd0 || fifo_overflow !== 1'b1) begin
      n_errors++;
      $display("FAIL flush_state: got empty=%0b count=%0d ovf=%0b, need empty=1 count=0 ovf=1", fifo_empty, flit_count, fifo_overflow);
    end
    for (int b = 1; b <= 4; b++) cyc(1, 8'(b), 0, 0, 0);
    n_checks++;
    if (flit !== 32'h04030201 || flit_count !== 3'd1) begin
      n_errors++;
      $display("FAIL flush_packer: got flit=%h count=%0d, need flit=04030201 count=1", flit, flit_count);
    end
  endtask

  task automatic test_random();
    bit          w, r, f, c;
    logic [9:0]  got_st, exp_st;
    logic [31:0] exp_head;
    int          cnt;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      w = ($urandom_range(99) < 70);
      r = ($urandom_range(99) < ((i / 100) % 2 == 0 ? 20 : 75));
      f = ($urandom_range(99) < 2);
      c = ($urandom_range(99) < 6);
      cyc(w, 8'($urandom), r, f, c);
      cnt = m_q.size();
      exp_st = {!(m_pend.size() == BPF-1 && cnt == DEPTH), cnt > 0, cnt == DEPTH, cnt == 0,
                cnt >= THRESH, m_ovf, m_udf, 3'(cnt)};
      got_st = {wr_ready, flit_avl, fifo_full, fifo_empty, fifo_threshold,
                fifo_overflow, fifo_underflow, flit_count};
      n_checks++;
      if (got_st !== exp_st) begin
        n_errors++;
        $display("FAIL rand_status cycle %0d: got rdy/avl/full/empty/thr/ovf/udf/cnt=%b, need %b", i, got_st, exp_st);
      end
      if (cnt > 0) begin
        exp_head = m_q[0];
        n_checks++;
        if (flit !== exp_head) begin
          n_errors++;
          $display("FAIL rand_head cycle %0d: got %h, need %h", i, flit, exp_head);
        end
      end
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_single_flit();
    test_fill_overflow();
    test_underflow();
    test_back_to_back();
    test_flush();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
